// File: rtl/fp_classify_pkg.sv
// Shared types and constants for the FP classify pipeline: format encoding,
// class-mask bit positions and per-format field widths.
package fp_classify_pkg;

  typedef enum logic [1:0] {
    FmtS    = 2'b00,
    FmtD    = 2'b01,
    FmtH    = 2'b10,
    FmtRsvd = 2'b11
  } fmt_e;

  localparam int unsigned ClsW       = 10;
  localparam int unsigned ClsNegInf  = 0;
  localparam int unsigned ClsNegNorm = 1;
  localparam int unsigned ClsNegSub  = 2;
  localparam int unsigned ClsNegZero = 3;
  localparam int unsigned ClsPosZero = 4;
  localparam int unsigned ClsPosSub  = 5;
  localparam int unsigned ClsPosNorm = 6;
  localparam int unsigned ClsPosInf  = 7;
  localparam int unsigned ClsSnan    = 8;
  localparam int unsigned ClsQnan    = 9;

  localparam logic [ClsW-1:0] CanonQnanMask = 10'h200;

  localparam int unsigned SExpW  = 8;
  localparam int unsigned SFracW = 23;
  localparam int unsigned DExpW  = 11;
  localparam int unsigned DFracW = 52;
  localparam int unsigned HExpW  = 5;
  localparam int unsigned HFracW = 10;

  localparam int unsigned MaxExpW  = DExpW;
  localparam int unsigned MaxFracW = DFracW;

endpackage

// File: rtl/fp_class_decode.sv
// Combinational classifier: right-aligned exponent/fraction fields plus sign
// and format in, one-hot class mask out (all zero for the reserved format).
module fp_class_decode
  import fp_classify_pkg::*;
(
  input  logic                sign,
  input  logic [MaxExpW-1:0]  exponent,
  input  logic [MaxFracW-1:0] fraction,
  input  logic [1:0]          fmt,
  output logic [ClsW-1:0]     mask
);

  fmt_e fmt_sel;
  logic legal;
  logic exp_ones;
  logic exp_zero;
  logic frac_zero;
  logic quiet;

  assign fmt_sel = fmt_e'(fmt);

  always_comb begin
    legal     = 1'b1;
    exp_ones  = 1'b0;
    exp_zero  = 1'b0;
    frac_zero = 1'b0;
    quiet     = 1'b0;
    case (fmt_sel)
      FmtS: begin
        exp_ones  = &exponent[SExpW-1:0];
        exp_zero  = ~|exponent[SExpW-1:0];
        frac_zero = ~|fraction[SFracW-1:0];
        quiet     = fraction[SFracW-1];
      end
      FmtD: begin
        exp_ones  = &exponent[DExpW-1:0];
        exp_zero  = ~|exponent[DExpW-1:0];
        frac_zero = ~|fraction[DFracW-1:0];
        quiet     = fraction[DFracW-1];
      end
      FmtH: begin
        exp_ones  = &exponent[HExpW-1:0];
        exp_zero  = ~|exponent[HExpW-1:0];
        frac_zero = ~|fraction[HFracW-1:0];
        quiet     = fraction[HFracW-1];
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    mask = '0;
    if (legal) begin
      if (exp_ones) begin
        if (frac_zero)  mask[sign ? ClsNegInf : ClsPosInf] = 1'b1;
        else if (quiet) mask[ClsQnan] = 1'b1;
        else            mask[ClsSnan] = 1'b1;
      end else if (exp_zero) begin
        if (frac_zero) mask[sign ? ClsNegZero : ClsPosZero] = 1'b1;
        else           mask[sign ? ClsNegSub : ClsPosSub] = 1'b1;
      end else begin
        mask[sign ? ClsNegNorm : ClsPosNorm] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_classify_pipe.sv
// FP classify unit: NaN-box/format screening and class decode ahead of an
// elastic valid/ready pipeline of STAGES registers carrying mask and tag.
module fp_classify_pipe
  import fp_classify_pkg::*;
#(
  parameter int unsigned FLEN   = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_fmt,
  input  logic [FLEN-1:0]  i_operand,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  logic [63:0]         op64;
  fmt_e                fmt;
  logic                f_sign;
  logic [MaxExpW-1:0]  f_exp;
  logic [MaxFracW-1:0] f_frac;
  logic                boxed;
  logic                supported;
  logic [ClsW-1:0]     dec_mask;
  logic [ClsW-1:0]     cls_in;

  assign op64 = 64'(i_operand);
  assign fmt  = fmt_e'(i_fmt);

  always_comb begin
    f_sign    = 1'b0;
    f_exp     = '0;
    f_frac    = '0;
    boxed     = 1'b1;
    supported = 1'b1;
    case (fmt)
      FmtS: begin
        f_sign = op64[SExpW+SFracW];
        f_exp  = MaxExpW'(op64[SExpW+SFracW-1:SFracW]);
        f_frac = MaxFracW'(op64[SFracW-1:0]);
        boxed  = (FLEN == 32) ? 1'b1 : &op64[63:32];
      end
      FmtD: begin
        supported = (FLEN == 64);
        f_sign    = op64[DExpW+DFracW];
        f_exp     = op64[DExpW+DFracW-1:DFracW];
        f_frac    = op64[DFracW-1:0];
      end
      FmtH: begin
        f_sign = op64[HExpW+HFracW];
        f_exp  = MaxExpW'(op64[HExpW+HFracW-1:HFracW]);
        f_frac = MaxFracW'(op64[HFracW-1:0]);
        boxed  = &op64[FLEN-1:16];
      end
      default: supported = 1'b0;
    endcase
  end

  fp_class_decode u_decode (
    .sign     (f_sign),
    .exponent (f_exp),
    .fraction (f_frac),
    .fmt      (i_fmt),
    .mask     (dec_mask)
  );

  // Unsupported format wins over the NaN-box check.
  assign cls_in = !supported ? '0 : (!boxed ? CanonQnanMask : dec_mask);

  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                valid_d;
  logic [STAGES-1:0]                ready_in;
  logic [STAGES-1:0]                in_valid;
  logic [STAGES-1:0]                load;
  logic [STAGES-1:0][ClsW-1:0]      res_q;
  logic [STAGES-1:0][ClsW-1:0]      in_res;
  logic [STAGES-1:0][TAG_W-1:0]     tag_q;
  logic [STAGES-1:0][TAG_W-1:0]     in_tag;

  // A stage can take a new entry if it is empty or its content moves on.
  always_comb begin
    logic rdy;
    rdy      = i_ready;
    ready_in = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy         = !valid_q[k] || rdy;
      ready_in[k] = rdy;
    end
  end

  always_comb begin
    in_valid    = '0;
    in_res      = '0;
    in_tag      = '0;
    load        = '0;
    valid_d     = '0;
    in_valid[0] = i_valid;
    in_res[0]   = cls_in;
    in_tag[0]   = i_tag;
    for (int k = 1; k < STAGES; k++) begin
      in_valid[k] = valid_q[k-1];
      in_res[k]   = res_q[k-1];
      in_tag[k]   = tag_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      load[k]    = ready_in[k] && in_valid[k] && !i_flush;
      valid_d[k] = i_flush ? 1'b0 : (ready_in[k] ? in_valid[k] : valid_q[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      res_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          res_q[k] <= in_res[k];
          tag_q[k] <= in_tag[k];
        end
      end
    end
  end

  assign o_ready  = ready_in[0];
  assign o_valid  = valid_q[STAGES-1];
  assign o_busy   = |valid_q;
  assign o_result = 32'(res_q[STAGES-1]);
  assign o_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Bench for fp_classify_pipe: directed vectors, a queue-based reference model
// checked on every cycle, and literal expectations for the known vectors.
module tb_fp_classify_pipe;

  localparam int unsigned FLEN   = 64;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             valid_in;
  logic             dut_ready;
  logic [1:0]       fmt;
  logic [FLEN-1:0]  operand;
  logic [TAG_W-1:0] tag;
  logic             dut_valid;
  logic             ready_out;
  logic [31:0]      result;
  logic [TAG_W-1:0] res_tag;
  logic             busy;

  always #5 clk = ~clk;

  fp_classify_pipe #(
    .FLEN   (FLEN),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_valid   (valid_in),
    .o_ready   (dut_ready),
    .i_fmt     (fmt),
    .i_operand (operand),
    .i_tag     (tag),
    .o_valid   (dut_valid),
    .i_ready   (ready_out),
    .o_result  (result),
    .o_tag     (res_tag),
    .o_busy    (busy)
  );

  typedef struct packed {
    logic [9:0]       res;
    logic [TAG_W-1:0] tag;
    logic             lit_en;
    logic [9:0]       lit;
  } exp_t;

  exp_t             q[$];
  int               n_vec = 0;
  int               n_fail = 0;
  logic             chk_en = 1'b0;
  logic             lit_en_cur = 1'b0;
  logic [9:0]       lit_cur = '0;
  logic             prev_stall = 1'b0;
  logic [31:0]      prev_res = '0;
  logic [TAG_W-1:0] prev_tag = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Classification straight from the IEEE field definitions.
  function automatic logic [9:0] model(input logic [1:0] f, input logic [63:0] op);
    int w, e, fw, idx;
    logic [63:0] upper, expo, frac;
    logic s;
    case (f)
      2'b00: begin w = 32; e = 8;  fw = 23; end
      2'b01: begin w = 64; e = 11; fw = 52; end
      2'b10: begin w = 16; e = 5;  fw = 10; end
      default: return 10'h000;
    endcase
    if (w > int'(FLEN)) return 10'h000;
    if (w < int'(FLEN)) begin
      upper = op >> w;
      if (upper != ((64'd1 << (int'(FLEN) - w)) - 64'd1)) return 10'h200;
    end
    s    = op[w-1];
    expo = (op >> fw) & ((64'd1 << e) - 64'd1);
    frac = op & ((64'd1 << fw) - 64'd1);
    if (expo == ((64'd1 << e) - 64'd1))
      idx = (frac == 0) ? (s ? 0 : 7) : (frac[fw-1] ? 9 : 8);
    else if (expo == 0)
      idx = (frac == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else
      idx = s ? 1 : 6;
    return 10'd1 << idx;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_ready", 32'(dut_ready), 32'(ready_out || (q.size() < int'(STAGES))));
      check("o_busy", 32'(busy), 32'(q.size() != 0));
      if (prev_stall) begin
        check("hold_valid", 32'(dut_valid), 32'd1);
        check("hold_result", result, prev_res);
        check("hold_tag", 32'(res_tag), 32'(prev_tag));
      end
      if (dut_valid) begin
        check("valid_has_entry", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check("result", result, 32'(q[0].res));
          check("tag", 32'(res_tag), 32'(q[0].tag));
          if (q[0].lit_en) check("literal", result, 32'(q[0].lit));
        end
      end
      prev_stall = dut_valid && !ready_out && !flush && !rst;
      prev_res   = result;
      prev_tag   = res_tag;
      if (dut_valid && ready_out && q.size() != 0) void'(q.pop_front());
      if (rst || flush) q.delete();
      else if (valid_in && dut_ready)
        q.push_back('{res: model(fmt, operand), tag: tag, lit_en: lit_en_cur, lit: lit_cur});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] f, input logic [63:0] op, input logic [TAG_W-1:0] t,
                      input logic le, input logic [9:0] l);
    valid_in   = 1'b1;
    fmt        = f;
    operand    = op;
    tag        = t;
    lit_en_cur = le;
    lit_cur    = l;
    step();
    valid_in   = 1'b0;
    lit_en_cur = 1'b0;
  endtask

  localparam int NV = 15;
  logic [1:0]  v_fmt[NV] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11,
                             2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
  logic [63:0] v_op[NV]  = '{64'hFFFFFFFF_7F800000, 64'h00000000_3F800000,
                             64'hFFF0000000000000, 64'h8000000000000001,
                             64'h7FF4000000000000, 64'h7FF8000000000000,
                             64'hFFFFFFFFFFFF8000, 64'hFFFFFFFFFFFF3C00,
                             64'h123456789ABCDEF0, 64'hFFFFFFFF_00000001,
                             64'h0000000000000000, 64'hFFFFFFFFFFFF7E00,
                             64'hFFFFFFFF_FF800001, 64'hBFF0000000000000,
                             64'hFFFFFFFFFFFFFC00};
  logic [9:0]  v_exp[NV] = '{10'h080, 10'h200, 10'h001, 10'h004, 10'h100, 10'h200,
                             10'h008, 10'h040, 10'h000, 10'h020, 10'h010, 10'h200,
                             10'h100, 10'h002, 10'h001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt, first, last;
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    fmt = '0; operand = '0; tag = '0;
    step();
    step();
    chk_en = 1'b1;
    check("rst_valid", 32'(dut_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag", 32'(res_tag), 32'd0);
    rst = 1'b0;
    check("ready_after_rst", 32'(dut_ready), 32'd1);

    // Latency of a single isolated request.
    send(2'b00, 64'hFFFFFFFF_7F800000, 5'd3, 1'b1, 10'h080);
    n = 1;
    while (!dut_valid && n < 10) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(STAGES));
    repeat (3) step();

    for (int i = 0; i < NV; i++) send(v_fmt[i], v_op[i], TAG_W'(10 + i), 1'b1, v_exp[i]);
    repeat (4) step();

    // Back-to-back: eight requests, result stream must be gap-free.
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        valid_in = 1'b1;
        fmt      = 2'b01;
        operand  = {1'b0, 11'(1000 + c), 52'(c)};
        tag      = TAG_W'(c);
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (dut_valid) begin
        cnt++;
        if (first < 0) first = c + 1;
        last = c + 1;
      end
    end
    check("b2b_count", 32'(cnt), 32'd8);
    check("b2b_first", 32'(first), 32'(STAGES));
    check("b2b_last", 32'(last), 32'(STAGES + 7));

    // Stall: consumer not ready for five cycles while requests keep coming.
    ready_out = 1'b0;
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      fmt      = 2'b10;
      operand  = {48'hFFFFFFFFFFFF, 16'(c * 16'h0400 + 1)};
      tag      = TAG_W'(20 + c);
      step();
    end
    check("stall_ready", 32'(dut_ready), 32'd0);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (4) step();

    // Flush with two entries in flight plus a new request.
    ready_out = 1'b0;
    send(2'b01, 64'h3FF0000000000000, 5'd26, 1'b1, 10'h040);
    send(2'b01, 64'hBFF0000000000000, 5'd27, 1'b1, 10'h002);
    flush = 1'b1;
    send(2'b01, 64'h7FF0000000000000, 5'd28, 1'b1, 10'h080);
    flush = 1'b0;
    check("flush_valid", 32'(dut_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    ready_out = 1'b1;
    repeat (4) step();

    // Flush coinciding with an output handshake.
    send(2'b00, 64'hFFFFFFFF_80000000, 5'd29, 1'b1, 10'h008);
    send(2'b00, 64'hFFFFFFFF_00000000, 5'd30, 1'b1, 10'h010);
    check("pre_flush_out", 32'(dut_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_hs_busy", 32'(busy), 32'd0);
    repeat (3) step();

    // Reset mid-stream.
    send(2'b10, 64'hFFFFFFFFFFFF3C00, 5'd31, 1'b1, 10'h040);
    send(2'b10, 64'hFFFFFFFFFFFF8000, 5'd1, 1'b1, 10'h008);
    rst = 1'b1;
    send(2'b10, 64'hFFFFFFFFFFFF7C00, 5'd2, 1'b0, 10'h000);
    rst = 1'b0;
    check("mid_rst_valid", 32'(dut_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_tag", 32'(res_tag), 32'd0);
    check("mid_rst_ready", 32'(dut_ready), 32'd1);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
